// File: rtl/pingpong_frame_arbiter_if.sv
// Bundle of host-write, display-handshake and status signals between the
// ping-pong frame arbiter and its neighbours (host port, display controller).
interface pingpong_frame_arbiter_if #(
   parameter int ADDR_W = 10,
   parameter int CNT_W  = 8
);
   // Host write handshake: a word transfers on every rising clk edge where
   // HostWrValid and HostWrReady are both 1; Valid may be raised without
   // waiting for Ready, and Ready depends only on arbiter state and reset.
   logic              HostWrValid;
   logic              HostWrReady;
   logic              SoftClear;
   logic              DispFrameEnd;
   logic              WE0;
   logic              WE1;
   logic [ADDR_W-1:0] WrAddr;
   logic              DispSel;
   logic              DispValid;
   logic              SwapPulse;
   logic              Buf0Empty;
   logic              Buf1Empty;
   logic [CNT_W-1:0]  RepeatCnt;
   logic [1:0]        ArbState;

   modport master (
      output HostWrValid, SoftClear, DispFrameEnd,
      input  HostWrReady, WE0, WE1, WrAddr, DispSel, DispValid, SwapPulse,
             Buf0Empty, Buf1Empty, RepeatCnt, ArbState
   );

   modport slave (
      input  HostWrValid, SoftClear, DispFrameEnd,
      output HostWrReady, WE0, WE1, WrAddr, DispSel, DispValid, SwapPulse,
             Buf0Empty, Buf1Empty, RepeatCnt, ArbState
   );
endinterface

// File: rtl/pingpong_frame_arbiter.sv
// Ping-pong ownership of two frame buffers: host fills one while the display
// scans the other; a finished buffer is handed over only at a frame boundary.
module pingpong_frame_arbiter #(
   parameter int ADDR_W = 10,
   parameter int DEPTH  = 768,
   parameter int CNT_W  = 8
) (
   input  logic                      clk,
   input  logic                      reset,
   pingpong_frame_arbiter_if.slave   bus
);

   typedef enum logic [1:0] {
      FILL0 = 2'd0,
      RUN   = 2'd1,
      FULL  = 2'd2
   } state_t;

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   state_t            state;
   logic              wr_sel;
   logic [ADDR_W-1:0] wr_addr;
   logic              disp_sel;
   logic              disp_valid;
   logic              swap_pulse;
   logic [1:0]        buf_empty;
   logic [CNT_W-1:0]  repeat_cnt;

   logic ready;
   logic accept;
   logic final_wr;

   // Ready is gated by reset directly so it drops the instant reset asserts.
   assign ready    = reset & (state != FULL);
   assign accept   = bus.HostWrValid & ready;
   assign final_wr = accept & (wr_addr == LAST_ADDR);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= FILL0;
         wr_sel     <= 1'b0;
         wr_addr    <= '0;
         disp_sel   <= 1'b0;
         disp_valid <= 1'b0;
         swap_pulse <= 1'b0;
         buf_empty  <= 2'b11;
         repeat_cnt <= '0;
      end else begin
         swap_pulse <= 1'b0;
         if (bus.SoftClear) begin
            state      <= FILL0;
            wr_sel     <= 1'b0;
            wr_addr    <= '0;
            disp_sel   <= 1'b0;
            disp_valid <= 1'b0;
            buf_empty  <= 2'b11;
            repeat_cnt <= '0;
         end else begin
            if (accept) begin
               wr_addr <= final_wr ? '0 : wr_addr + 1'b1;
            end
            case (state)
               FILL0: begin
                  if (final_wr) begin
                     state        <= RUN;
                     buf_empty[0] <= 1'b0;
                     disp_sel     <= 1'b0;
                     disp_valid   <= 1'b1;
                     wr_sel       <= 1'b1;
                     swap_pulse   <= 1'b1;
                  end
               end
               RUN: begin
                  if (final_wr && bus.DispFrameEnd) begin
                     // Frame boundary coincides with completion: hand over now.
                     disp_sel            <= wr_sel;
                     wr_sel              <= disp_sel;
                     wr_addr             <= '0;
                     swap_pulse          <= 1'b1;
                     buf_empty[wr_sel]   <= 1'b0;
                     buf_empty[disp_sel] <= 1'b1;
                  end else if (final_wr) begin
                     state             <= FULL;
                     buf_empty[wr_sel] <= 1'b0;
                  end else if (bus.DispFrameEnd) begin
                     if (repeat_cnt != '1) begin
                        repeat_cnt <= repeat_cnt + 1'b1;
                     end
                  end
               end
               FULL: begin
                  if (bus.DispFrameEnd) begin
                     state               <= RUN;
                     disp_sel            <= wr_sel;
                     wr_sel              <= disp_sel;
                     wr_addr             <= '0;
                     swap_pulse          <= 1'b1;
                     buf_empty[wr_sel]   <= 1'b0;
                     buf_empty[disp_sel] <= 1'b1;
                  end
               end
               default: begin
                  state <= FILL0;
               end
            endcase
         end
      end
   end

   assign bus.HostWrReady = ready;
   assign bus.WE0         = accept & ~wr_sel;
   assign bus.WE1         = accept & wr_sel;
   assign bus.WrAddr      = wr_addr;
   assign bus.DispSel     = disp_sel;
   assign bus.DispValid   = disp_valid;
   assign bus.SwapPulse   = swap_pulse;
   assign bus.Buf0Empty   = buf_empty[0];
   assign bus.Buf1Empty   = buf_empty[1];
   assign bus.RepeatCnt   = repeat_cnt;
   assign bus.ArbState    = state;

   // The displayed buffer is never the one being written, and it is complete.
   a_disp_invariant : assert property (@(posedge clk) disable iff (!reset)
      disp_valid |-> ((wr_sel != disp_sel) && !buf_empty[disp_sel]));

endmodule
